// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
//   lsu_size_t  - access size as encoded on req_size (3 folds to word)
//   lsu_state_t - FSM state, also exported on the debug port
//   *_W         - lane widths used for extraction/merge
//   norm_size() - maps the raw 2-bit size field onto lsu_size_t
package lsu_pkg;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } lsu_size_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_RESP  = 3'd2,
    ST_MERGE = 3'd3,
    ST_WRITE = 3'd4
  } lsu_state_t;

  // Encoding 3 is not a distinct size; it behaves exactly like a word.
  function automatic lsu_size_t norm_size(input logic [1:0] s);
    lsu_size_t r;
    case (s)
      2'd0:    r = SIZE_BYTE;
      2'd1:    r = SIZE_HALF;
      default: r = SIZE_WORD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if: request/response channel between execute stage and the LSU.
//   master modport: execute stage (drives req_*, observes req_ready/rsp_*)
//   slave  modport: load_store_unit
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1; req_ready is high only while the LSU is idle.
// rsp_valid is a single-cycle pulse; rsp_rdata/rsp_err are only
// meaningful while it is high.
interface lsu_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/lsu_lane.sv
// lsu_lane: combinational lane logic for the load/store unit.
//   rd_word     in  word read from data memory
//   wdata       in  right-aligned store data
//   lane_addr   in  byte address bits [1:0]
//   size        in  access size
//   is_unsigned in  1 = zero-extend loads, 0 = sign-extend
//   ext_data    out extracted and extended load result
//   merged_word out rd_word with the addressed lane replaced by wdata
// Halves use only lane_addr[1]; words ignore lane_addr entirely.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane_addr,
  input  lsu_size_t   size,
  input  logic        is_unsigned,
  output logic [31:0] ext_data,
  output logic [31:0] merged_word
);

  logic [BYTE_W-1:0] byte_sel;
  logic [HALF_W-1:0] half_sel;
  logic              byte_sign;
  logic              half_sign;

  always_comb begin
    byte_sel    = rd_word[{lane_addr, 3'b000} +: BYTE_W];
    half_sel    = rd_word[{lane_addr[1], 4'b0000} +: HALF_W];
    byte_sign   = byte_sel[BYTE_W-1] & ~is_unsigned;
    half_sign   = half_sel[HALF_W-1] & ~is_unsigned;
    ext_data    = rd_word;
    merged_word = wdata;
    case (size)
      SIZE_BYTE: begin
        ext_data    = {{(WORD_W-BYTE_W){byte_sign}}, byte_sel};
        merged_word = rd_word;
        merged_word[{lane_addr, 3'b000} +: BYTE_W] = wdata[BYTE_W-1:0];
      end
      SIZE_HALF: begin
        ext_data    = {{(WORD_W-HALF_W){half_sign}}, half_sel};
        merged_word = rd_word;
        merged_word[{lane_addr[1], 4'b0000} +: HALF_W] = wdata[HALF_W-1:0];
      end
      default: begin
        ext_data    = rd_word;
        merged_word = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage between execute and data memory.
// Accepts one load/store at a time, does sub-word stores as
// read-modify-write and returns extended load data with a 1-cycle pulse.
//   clk, rst          clock, asynchronous active-low reset
//   bus (lsu_if.slave) request/response channel
//   mem_read_addr     registered read address (1-cycle registered memory)
//   mem_read_data     read data, valid the cycle after the address edge
//   mem_write_*       registered write port; enable high only in WRITE
//   dbg_state         current FSM state
// Optional feature: define LSU_MISALIGN_CHECK_EN to reject misaligned
// halves/words with rsp_err instead of silently aligning them.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_SIZE = 7
) (
  input  logic        clk,
  input  logic        rst,
  lsu_if.slave        bus,
  output logic [31:0] mem_read_addr,
  input  logic [31:0] mem_read_data,
  output logic [31:0] mem_write_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable,
  output lsu_state_t  dbg_state
);

  lsu_state_t  state_q, state_d;
  logic        write_q, write_d;
  lsu_size_t   size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rd_addr_q, rd_addr_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        we_q, we_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  lsu_size_t   req_size_n;
  logic        misalign;
  logic [31:0] ext_data;
  logic [31:0] merged_word;

  // Memory sees only addr[ADDR_SIZE:2], in place; every other bit is 0.
  function automatic logic [31:0] word_addr(input logic [31:0] a);
    logic [31:0] r;
    r = '0;
    r[ADDR_SIZE:2] = a[ADDR_SIZE:2];
    return r;
  endfunction

  assign req_size_n = norm_size(bus.req_size);

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign = ((req_size_n == SIZE_HALF) && bus.req_addr[0]) ||
                    ((req_size_n == SIZE_WORD) && (bus.req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  lsu_lane u_lane (
    .rd_word     (mem_read_data),
    .wdata       (wdata_q),
    .lane_addr   (lane_q),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .ext_data    (ext_data),
    .merged_word (merged_word)
  );

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    size_d      = size_q;
    unsigned_d  = unsigned_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    rd_addr_d   = rd_addr_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    we_d        = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          write_d    = bus.req_write;
          size_d     = req_size_n;
          unsigned_d = bus.req_unsigned;
          lane_d     = bus.req_addr[1:0];
          wdata_d    = bus.req_wdata;
          if (misalign) begin
            // Completes immediately with no memory traffic.
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (bus.req_write && (req_size_n == SIZE_WORD)) begin
            wr_addr_d = word_addr(bus.req_addr);
            wr_data_d = bus.req_wdata;
            we_d      = 1'b1;
            state_d   = ST_WRITE;
          end else begin
            rd_addr_d = word_addr(bus.req_addr);
            state_d   = ST_READ;
          end
        end
      end
      ST_READ:  state_d = write_q ? ST_MERGE : ST_RESP;
      ST_RESP: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = ext_data;
        state_d     = ST_IDLE;
      end
      ST_MERGE: begin
        // The RMW writes back to the word just read.
        wr_addr_d = rd_addr_q;
        wr_data_d = merged_word;
        we_d      = 1'b1;
        state_d   = ST_WRITE;
      end
      ST_WRITE: begin
        rsp_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      write_q     <= 1'b0;
      size_q      <= SIZE_BYTE;
      unsigned_q  <= 1'b0;
      lane_q      <= 2'b00;
      wdata_q     <= '0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      we_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      size_q      <= size_d;
      unsigned_q  <= unsigned_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      we_q        <= we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready   = (state_q == ST_IDLE);
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign mem_read_addr    = rd_addr_q;
  assign mem_write_addr   = wr_addr_q;
  assign mem_write_data   = wr_data_q;
  assign mem_write_enable = we_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural data memory
// (1-cycle registered read, read-first, word-indexed by addr[7:2]).
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] mem_read_addr;
  logic [31:0] mem_read_data;
  logic [31:0] mem_write_addr;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  lsu_state_t  dbg_state;

  lsu_if bus ();

  load_store_unit #(.ADDR_SIZE(7)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .mem_read_addr    (mem_read_addr),
    .mem_read_data    (mem_read_data),
    .mem_write_addr   (mem_write_addr),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .dbg_state        (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data memory model
  logic [31:0] mem [0:63];
  int          write_cnt;
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem_read_data = '0;
    write_cnt = 0;
  end
  always @(posedge clk) begin
    mem_read_data <= mem[mem_read_addr[7:2]];
    if (mem_write_enable) begin
      mem[mem_write_addr[7:2]] <= mem_write_data;
      write_cnt <= write_cnt + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver: present a request at a negedge, hold through the accept edge
  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_write    = w;
    bus.req_size     = sz;
    bus.req_unsigned = u;
    bus.req_addr     = a;
    bus.req_wdata    = d;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'hFFFF_FFFF;
    bus.req_wdata = 32'h0BAD_0BAD;
  endtask

  // lat = number of rising edges after the accept edge until rsp_valid rose
  task automatic wait_rsp(output int lat, output logic [31:0] rdata, output logic err);
    lat = 0;
    while (!bus.rsp_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.rsp_valid) lat = 99;
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
  endtask

  int          lat;
  logic [31:0] rd;
  logic        er;
  int          acc_n, rsp_n, rdy_low, rdata_ok;
  int          acc_c [3];

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #10;
    check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    check("rst_we", {31'd0, mem_write_enable}, 32'd0);
    check("rst_raddr", mem_read_addr, 32'd0);
    check("rst_waddr", mem_write_addr, 32'd0);
    check("rst_wdata", mem_write_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // word store then word load
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    wait_rsp(lat, rd, er);
    check("sw_lat", lat, 32'd1);
    check("sw_rdata", rd, 32'd0);
    @(negedge clk);
    check("sw_mem", mem[4], 32'hDEADBEEF);

    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    wait_rsp(lat, rd, er);
    check("lw_lat", lat, 32'd2);
    check("lw_rdata", rd, 32'hDEADBEEF);
    check("lw_err", {31'd0, er}, 32'd0);

    // byte store (upper wdata bits must be ignored)
    issue(1'b1, 2'd0, 1'b0, 32'h11, 32'h123456AA);
    wait_rsp(lat, rd, er);
    check("sb_lat", lat, 32'd3);
    @(negedge clk);
    check("sb_mem", mem[4], 32'hDEADAAEF);

    issue(1'b0, 2'd0, 1'b0, 32'h11, 32'h0);
    wait_rsp(lat, rd, er);
    check("lb_rdata", rd, 32'hFFFFFFAA);
    check("lb_lat", lat, 32'd2);
    issue(1'b0, 2'd0, 1'b1, 32'h11, 32'h0);
    wait_rsp(lat, rd, er);
    check("lbu_rdata", rd, 32'h000000AA);

    // half store and loads
    issue(1'b1, 2'd1, 1'b0, 32'h12, 32'hABCD1234);
    wait_rsp(lat, rd, er);
    check("sh_lat", lat, 32'd3);
    @(negedge clk);
    check("sh_mem", mem[4], 32'h1234AAEF);

    issue(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
    wait_rsp(lat, rd, er);
    check("lh12_rdata", rd, 32'h00001234);
    issue(1'b0, 2'd1, 1'b0, 32'h10, 32'h0);
    wait_rsp(lat, rd, er);
    check("lh10_rdata", rd, 32'hFFFFAAEF);

    // size encoding 3 behaves as word
    issue(1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
    wait_rsp(lat, rd, er);
    check("lsz3_rdata", rd, 32'h1234AAEF);

    // misaligned word load
    issue(1'b0, 2'd2, 1'b0, 32'h13, 32'h0);
    wait_rsp(lat, rd, er);
`ifdef LSU_MISALIGN_CHECK_EN
    check("mis_lat", lat, 32'd0);
    check("mis_rdata", rd, 32'd0);
    check("mis_err", {31'd0, er}, 32'd1);
`else
    check("mis_lat", lat, 32'd2);
    check("mis_rdata", rd, 32'h1234AAEF);
    check("mis_err", {31'd0, er}, 32'd0);
`endif
    @(negedge clk);
    check("write_cnt_a", write_cnt, 32'd3);

    // reset asserted during MERGE of a byte store
    issue(1'b1, 2'd0, 1'b0, 32'h10, 32'h55);
    @(posedge clk);
    #1;
    check("merge_state", {29'd0, dbg_state}, {29'd0, ST_MERGE});
    #1 rst = 1'b0;
    #1;
    check("arst_ready", {31'd0, bus.req_ready}, 32'd1);
    check("arst_we", {31'd0, mem_write_enable}, 32'd0);
    check("arst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("arst_mem", mem[4], 32'h1234AAEF);
    check("arst_write_cnt", write_cnt, 32'd3);
    check("arst_ready_after", {31'd0, bus.req_ready}, 32'd1);

    // three back-to-back loads with req_valid held high
    acc_n = 0; rsp_n = 0; rdy_low = 0; rdata_ok = 0;
    bus.req_valid    = 1'b1;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'd2;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h10;
    for (int c = 0; c < 12; c++) begin
      if (bus.rsp_valid) begin
        rsp_n++;
        if (bus.rsp_rdata === 32'h1234AAEF) rdata_ok++;
      end
      if (!bus.req_ready) rdy_low++;
      if (bus.req_ready && bus.req_valid && acc_n < 3) begin
        acc_c[acc_n] = c;
        acc_n++;
      end
      @(posedge clk);
      #1;
      if (acc_n == 3) bus.req_valid = 1'b0;
      @(negedge clk);
    end
    check("b2b_accepts", acc_n, 32'd3);
    check("b2b_gap1", acc_c[1] - acc_c[0], 32'd3);
    check("b2b_gap2", acc_c[2] - acc_c[1], 32'd3);
    check("b2b_rsp_pulses", rsp_n, 32'd3);
    check("b2b_rdata", rdata_ok, 32'd3);
    check("b2b_ready_low", rdy_low, 32'd6);
    check("write_cnt_end", write_cnt, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage between the core's execute stage and the single-port-per-direction data memory (1-cycle registered read, read-first, word-indexed by `addr[ADDR_SIZE:2]`, no byte enables). Accepts one load/store request at a time over a valid/ready handshake. Performs byte/halfword stores as read-modify-write and returns sign- or zero-extended load data with a one-cycle response pulse. It is the only writer of the data memory.

## Interface
- `ADDR_SIZE`, default 7: must match the data memory. Only `addr[ADDR_SIZE:2]` is meaningful. Memory address outputs carry `req_addr[ADDR_SIZE:2]` at the same bit positions; all other bits are 0.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE; transfer on `req_valid && req_ready` at a rising edge (the accept edge, E0).
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  0 byte, 1 half, 2 word; 3 is treated as word.
- `req_unsigned`  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- `req_addr`  in  32  byte address, little-endian.
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid`  out  1  one-cycle pulse marking completion of each accepted request.
- `rsp_rdata`  out  32  load result, valid while `rsp_valid`; 0 for stores.
- `rsp_err`  out  1  misaligned access flag, valid while `rsp_valid`.
- `mem_read_addr`  out  32  to data memory `read_addr`; registered.
- `mem_read_data`  in  32  from data memory `read_data`.
- `mem_write_addr`, `mem_write_data`  out  32 each  to data memory; registered.
- `mem_write_enable`  out  1  to data memory; registered.

## Operation
- States: IDLE, READ, RESP, MERGE, WRITE.
- IDLE:
  - Word store → WRITE, with `mem_write_*` loaded at E0.
  - Load → READ, with `mem_read_addr` loaded at E0.
  - Sub-word store → READ.
- READ: the memory samples the address at the end of this cycle. Next state is RESP for loads, MERGE for stores.
- RESP: `mem_read_data` is valid. Extract the lane, extend it, register it into `rsp_rdata`, then → IDLE.
- MERGE: `mem_read_data` is valid. Replace the addressed lane with `req_wdata`, load `mem_write_*` with the merged word and `mem_write_enable`=1, then → WRITE.
- WRITE: `mem_write_enable`=1 for exactly this cycle, then → IDLE.
- Lane selection: byte lane = `addr[1:0]`, bits `8*addr[1:0] +: 8`. Half lane = `addr[1]`, bits `16*addr[1] +: 16`.
- Sign extension replicates the top bit of the extracted lane.
- All request fields are latched at E0. Upstream may change them after E0.
- Reset (asynchronous assert): state → IDLE. All outputs go to 0 immediately except `req_ready`, which goes to 1. An in-flight RMW or write is abandoned and memory is left unmodified unless the write edge has already occurred.

## Timing
- Reset values: `req_ready`=1; all other outputs 0.
- Load: E0 → READ → RESP. `rsp_valid`=1 in the cycle after E2, i.e. 2 cycles after the accept edge.
- Word store: write occurs at E1. `rsp_valid` in the cycle after E1.
- Sub-word store: read at E1, write at E3. `rsp_valid` in the cycle after E3.
- `rsp_valid` coincides with IDLE (`req_ready`=1). A new request is accepted in that same cycle.
- Throughput: loads 1 per 3 cycles, word stores 1 per 2 cycles, sub-word stores 1 per 4 cycles.
- `mem_write_enable` is never asserted outside WRITE.

## Configuration
- Macro `LSU_MISALIGN_CHECK_EN`.
- Defined: a half with `addr[0]`=1, or a word with `addr[1:0]`≠0, is accepted but does no memory access. The unit stays in IDLE, and the next cycle carries `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0.
- Undefined: no misalignment check. Halves ignore `addr[0]` and words ignore `addr[1:0]`. `rsp_err` is tied 0.

## Structure
- Package `lsu_pkg` holds:
  - enum `lsu_size_t` (`SIZE_BYTE`, `SIZE_HALF`, `SIZE_WORD`);
  - enum `lsu_state_t`;
  - lane-width localparams.
- Sub-module `lsu_lane` (combinational) provides:
  - `extract(word, addr[1:0], size, unsigned)`, producing the extended result;
  - `merge(word, wdata, addr[1:0], size)`, producing the new word.
- The top level holds the FSM and registers.

## Test plan
- Word store 0x10 ← 0xDEADBEEF, then word load 0x10 → `rsp_rdata`=0xDEADBEEF; `rsp_valid` exactly 2 cycles after the load's accept edge.
- Byte store 0x11 ← 0xAA → memory[0x10]=0xDEADAAEF. Signed byte load 0x11 → 0xFFFFFFAA; unsigned → 0x000000AA.
- Half store 0x12 ← 0x1234 → memory[0x10]=0x1234AAEF. Signed half load 0x12 → 0x00001234. Signed half load 0x10 → 0xFFFFAAEF.
- Word load 0x13: with `LSU_MISALIGN_CHECK_EN`, `rsp_err`=1, `rsp_rdata`=0, no memory read or write; without it, returns 0x1234AAEF with `rsp_err`=0.
- Reset asserted during MERGE of byte store 0x10 ← 0x55 → `mem_write_enable` never rises, memory[0x10] unchanged, `req_ready`=1 after release.
- `req_valid` held high with three back-to-back loads → accepts 3 cycles apart, `req_ready` low outside IDLE, three `rsp_valid` pulses.
